microwave_timer: RTL and testbench
==================================

Name: microwave_timer

Overview:
- Cooking-time controller directly upstream of seg7_driver.
- Accepts keypad digits and start/stop/door controls, and counts the time down at 1 Hz.
- Drives the three BCD digits (seconds_ones, seconds_tens, minutes) that seg7_driver decodes.
- Also drives the magnetron enable and a done indication.

Parameters:
- CLK_DIV, 50_000_000, clock cycles per 1-second tick (≥2; benches use 4).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- key_valid  in  1  one-cycle strobe: key_digit is valid.
- key_digit  in  4  BCD digit 0-9; values >9 are ignored.
- start  in  1  one-cycle start/resume strobe.
- stop  in  1  one-cycle pause/clear strobe.
- door_closed  in  1  level; 1 = door shut.
- seconds_ones  out  4  BCD 0-9.
- seconds_tens  out  4  BCD 0-5.
- minutes  out  4  BCD 0-9.
- magnetron_on  out  1  high only in RUN.
- done  out  1  high in DONE state.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All digits 0, magnetron_on=0, done=0, state IDLE, prescaler 0.
  - Reset mid-RUN aborts immediately.
- States: IDLE, SET, RUN, PAUSE, DONE. All outputs are registered; a state change is visible the cycle after the causing input.
- Input priority within one cycle: stop > door open > start > key.
- IDLE / SET key entry (key_valid, digit≤9):
  - Digits shift left: minutes<=seconds_tens, seconds_tens<=seconds_ones, seconds_ones<=key_digit. State goes to SET.
  - The key is ignored if current seconds_ones>5, so seconds_tens never exceeds 5.
  - The old minutes value is discarded.
- SET transitions:
  - start with door_closed=1 and nonzero time -> RUN.
  - start with time 0:00 is ignored.
  - stop -> IDLE, digits cleared to 0.
- RUN:
  - Prescaler counts 0..CLK_DIV-1 and is cleared on RUN entry, so the first decrement lands exactly CLK_DIV cycles after entry.
  - Each wrap decrements the time in BCD:
    - ones>0: ones-1.
    - ones=0, tens>0: ones=9, tens-1.
    - ones=0, tens=0: ones=9, tens=5, minutes-1.
  - A decrement that yields 0:00 moves to DONE in the same edge.
  - stop or door_closed=0 -> PAUSE. The prescaler value is held, not cleared.
  - key and start are ignored.
- PAUSE:
  - Digits frozen.
  - start with door_closed=1 -> RUN (prescaler restarts from 0).
  - start with door open is ignored.
  - stop -> IDLE, digits cleared.
  - Keys are ignored.
- DONE:
  - done=1, digits read 0:00.
  - Any of stop, key_valid, or door_closed falling to 0 -> IDLE with done=0. The key is consumed, not entered.
  - start is ignored.
- Maximum entry is 9:59. Time is never negative, and the counter does not wrap below 0:00.

Optional Feature:
- MICROWAVE_QUICK_START_EN:
  - Defined: start in IDLE with door_closed=1 loads 0:30 and enters RUN in the same edge. start in SET with 0:00 also loads 0:30.
  - Undefined: start in IDLE is ignored, and zero-time start is ignored everywhere.

Decomposition:
- Package microwave_pkg holds:
  - State enum (IDLE=0, SET=1, RUN=2, PAUSE=3, DONE=4, 3-bit).
  - BCD digit typedef (4-bit).
  - Constants MAX_TENS=5 and QUICK_START seconds_tens=3.
- One sub-module, bcd_time_decrementer:
  - Combinational; takes minutes/tens/ones.
  - Returns the decremented digits plus an is_zero flag.
  - Instantiated once.

Test Plan:
- Reset, keys 1,3,0 -> digits 1:30, state SET, magnetron_on=0.
- 0:03 entered, start, CLK_DIV=4 -> decrements at cycles 4, 8, 12 after start. Digits go 0:02, 0:01, 0:00; done=1 and magnetron_on=0 at the third decrement.
- Borrow: 1:00 running -> next tick shows 0:59. 0:10 -> 0:09.
- 0:05 running, door_closed=0 after 2 cycles -> PAUSE, digits hold 0:05. Door closes, start -> RUN, first decrement 4 cycles later. stop during PAUSE -> IDLE, 0:00.
- Keys 7 then 4 -> 0:07 then the 4 is ignored (ones=7>5). start at 0:00 in IDLE -> no change without the macro; with MICROWAVE_QUICK_START_EN -> 0:30 and RUN.
- stop and start asserted in the same cycle while in SET -> IDLE, digits cleared. rst_n low mid-RUN -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/microwave_pkg.sv
`default_nettype none
// ============================================================================
// Module   : microwave_pkg
// Brief    : Shared state encoding, BCD digit type and time constants.
// Revision : 1.0 - initial release
// ============================================================================
package microwave_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SET   = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t MAX_TENS         = 4'd5;
  localparam bcd_t QUICK_START_TENS = 4'd3;

endpackage
`default_nettype wire

// File: rtl/bcd_time_decrementer.sv
`default_nettype none
// ============================================================================
// Module   : bcd_time_decrementer
// Brief    : Combinational one-second BCD decrement of M:SS; saturates at 0:00.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_time_decrementer
  import microwave_pkg::*;
(
  input  logic [3:0] min_in,
  input  logic [3:0] tens_in,
  input  logic [3:0] ones_in,
  output logic [3:0] min_out,
  output logic [3:0] tens_out,
  output logic [3:0] ones_out,
  output logic       is_zero
);

  always_comb begin
    min_out  = min_in;
    tens_out = tens_in;
    ones_out = ones_in;
    if (ones_in != 4'd0) begin
      ones_out = ones_in - 4'd1;
    end else if (tens_in != 4'd0) begin
      ones_out = 4'd9;
      tens_out = tens_in - 4'd1;
    end else if (min_in != 4'd0) begin
      ones_out = 4'd9;
      tens_out = MAX_TENS;
      min_out  = min_in - 4'd1;
    end
  end

  // Flags the decremented result, so the caller can enter DONE on the same edge.
  assign is_zero = (min_out == 4'd0) && (tens_out == 4'd0) && (ones_out == 4'd0);

endmodule
`default_nettype wire

// File: rtl/microwave_timer.sv
`default_nettype none
// ============================================================================
// Module   : microwave_timer
// Brief    : Keypad cook-time entry and 1 Hz BCD countdown feeding seg7_driver.
//            Optional MICROWAVE_QUICK_START_EN: zero-time start loads 0:30.
// Revision : 1.0 - initial release
// ============================================================================
module microwave_timer
  import microwave_pkg::*;
#(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  output logic [3:0] seconds_ones,
  output logic [3:0] seconds_tens,
  output logic [3:0] minutes,
  output logic       magnetron_on,
  output logic       done
);

  localparam int                   c_presc_w   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_presc_w-1:0] c_presc_max = c_presc_w'(CLK_DIV - 1);

  state_t               r_state, w_next_state;
  bcd_t                 r_ones, r_tens, r_min;
  bcd_t                 w_ones_nx, w_tens_nx, w_min_nx;
  logic [c_presc_w-1:0] r_presc, w_presc_nx;
  logic                 r_magnetron, r_done;
  logic                 w_magnetron_nx, w_done_nx;

  bcd_t w_dec_ones, w_dec_tens, w_dec_min;
  logic w_dec_zero;
  logic w_time_zero;
  logic w_key_ok;

  bcd_time_decrementer u_dec (
    .min_in   (r_min),
    .tens_in  (r_tens),
    .ones_in  (r_ones),
    .min_out  (w_dec_min),
    .tens_out (w_dec_tens),
    .ones_out (w_dec_ones),
    .is_zero  (w_dec_zero)
  );

  assign w_time_zero = (r_min == 4'd0) && (r_tens == 4'd0) && (r_ones == 4'd0);
  // Refusing a key while ones > 5 keeps the shifted-in tens digit a legal 0-5.
  assign w_key_ok    = key_valid && (key_digit <= 4'd9) && (r_ones <= MAX_TENS);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ones      <= 4'd0;
      r_tens      <= 4'd0;
      r_min       <= 4'd0;
      r_presc     <= '0;
      r_magnetron <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_ones      <= w_ones_nx;
      r_tens      <= w_tens_nx;
      r_min       <= w_min_nx;
      r_presc     <= w_presc_nx;
      r_magnetron <= w_magnetron_nx;
      r_done      <= w_done_nx;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_ones_nx    = r_ones;
    w_tens_nx    = r_tens;
    w_min_nx     = r_min;
    w_presc_nx   = r_presc;
    case (r_state)
      IDLE, SET: begin
        if (stop) begin
          w_next_state = IDLE;
          w_ones_nx    = 4'd0;
          w_tens_nx    = 4'd0;
          w_min_nx     = 4'd0;
        end else if (start) begin
          if (door_closed && !w_time_zero) begin
            w_next_state = RUN;
            w_presc_nx   = '0;
          end
`ifdef MICROWAVE_QUICK_START_EN
          else if (door_closed) begin
            w_next_state = RUN;
            w_presc_nx   = '0;
            w_ones_nx    = 4'd0;
            w_tens_nx    = QUICK_START_TENS;
            w_min_nx     = 4'd0;
          end
`endif
        end else if (w_key_ok) begin
          w_next_state = SET;
          w_min_nx     = r_tens;
          w_tens_nx    = r_ones;
          w_ones_nx    = key_digit;
        end
      end
      RUN: begin
        if (stop || !door_closed) begin
          w_next_state = PAUSE;
        end else if (r_presc == c_presc_max) begin
          w_presc_nx = '0;
          w_ones_nx  = w_dec_ones;
          w_tens_nx  = w_dec_tens;
          w_min_nx   = w_dec_min;
          if (w_dec_zero) begin
            w_next_state = DONE;
          end
        end else begin
          w_presc_nx = r_presc + 1'b1;
        end
      end
      PAUSE: begin
        if (stop) begin
          w_next_state = IDLE;
          w_ones_nx    = 4'd0;
          w_tens_nx    = 4'd0;
          w_min_nx     = 4'd0;
        end else if (start && door_closed) begin
          w_next_state = RUN;
          w_presc_nx   = '0;
        end
      end
      DONE: begin
        if (stop || key_valid || !door_closed) begin
          w_next_state = IDLE;
          w_ones_nx    = 4'd0;
          w_tens_nx    = 4'd0;
          w_min_nx     = 4'd0;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_ones_nx    = 4'd0;
        w_tens_nx    = 4'd0;
        w_min_nx     = 4'd0;
        w_presc_nx   = '0;
      end
    endcase
  end

  // Decoded from the next state so the registered flags track r_state exactly.
  always_comb begin
    w_magnetron_nx = (w_next_state == RUN);
    w_done_nx      = (w_next_state == DONE);
  end

  assign seconds_ones = r_ones;
  assign seconds_tens = r_tens;
  assign minutes      = r_min;
  assign magnetron_on = r_magnetron;
  assign done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_microwave_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_microwave_timer
// Brief    : Directed self-checking bench for microwave_timer with CLK_DIV=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_microwave_timer;
  import microwave_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       start;
  logic       stop;
  logic       door_closed;
  logic [3:0] seconds_ones;
  logic [3:0] seconds_tens;
  logic [3:0] minutes;
  logic       magnetron_on;
  logic       done;

  int total = 0;
  int bad   = 0;

  microwave_timer #(.CLK_DIV(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_valid    (key_valid),
    .key_digit    (key_digit),
    .start        (start),
    .stop         (stop),
    .door_closed  (door_closed),
    .seconds_ones (seconds_ones),
    .seconds_tens (seconds_tens),
    .minutes      (minutes),
    .magnetron_on (magnetron_on),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on falling edges; outputs are read there too.
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_key(input logic [3:0] d);
    @(negedge clk);
    key_valid = 1'b1;
    key_digit = d;
    @(negedge clk);
    key_valid = 1'b0;
    key_digit = 4'd0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycles(3);
    total++;
    if ({minutes, seconds_tens, seconds_ones} !== 12'h000) begin
      bad++;
      $display("FAIL reset_digits: got %h want 000", {minutes, seconds_tens, seconds_ones});
    end
    total++;
    if ({magnetron_on, done} !== 2'b00) begin
      bad++;
      $display("FAIL reset_flags: got %b want 00", {magnetron_on, done});
    end
    total++;
    if (dut.r_state !== IDLE) begin
      bad++;
      $display("FAIL reset_state: got %0d want %0d", dut.r_state, IDLE);
    end
    rst_n = 1'b1;
    cycles(1);
  endtask

  task automatic test_key_entry();
    press_key(4'd1);
    press_key(4'd3);
    press_key(4'd0);
    total++;
    if ({minutes, seconds_tens, seconds_ones} !== 12'h130) begin
      bad++;
      $display("FAIL key_130: got %h want 130", {minutes, seconds_tens, seconds_ones});
    end
    total++;
    if (dut.r_state !== SET || magnetron_on !== 1'b0) begin
      bad++;
      $display("FAIL key_state: got state=%0d mag=%b want state=%0d mag=0", dut.r_state, magnetron_on, SET);
    end
    press_key(4'd5);
    total++;
    if ({minutes, seconds_tens, seconds_ones} !== 12'h305) begin
      bad++;
      $display("FAIL key_drop_min: got %h want 305", {minutes, seconds_tens, seconds_ones});
    end
    pulse_stop();
    total++;
    if ({minutes, seconds_tens, seconds_ones} !== 12'h000 || dut.r_state !== IDLE) begin
      bad++;
      $display("FAIL set_stop: got %h state=%0d want 000 state=%0d", {minutes, seconds_tens, seconds_ones}, dut.r_state, IDLE);
    end
  endtask

  task automatic test_countdown();
    press_key(4'd3);
    pulse_start();
    total++;
    if (magnetron_on !== 1'b1 || {minutes, seconds_tens, seconds_ones} !== 12'h003) begin
      bad++;
      $display("FAIL run_entry: got mag=%b %h want mag=1 003", magnetron_on, {minutes, seconds_tens, seconds_ones});
    end
    cycles(3);
    total++;
    if ({minutes, seconds_tens, seconds_ones} !== 12'h003) begin
      bad++;
      $display("FAIL early_dec: got %h want 003", {minutes, seconds_tens, seconds_ones});
    end
    cycles(1);
    total++;
    if ({minutes, seconds_tens, seconds_ones} !== 12'h002) begin
      bad++;
      $display("FAIL dec1: got %h want 002", {minutes, seconds_tens, seconds_ones});
    end
    cycles(4);
    total++;
    if ({minutes, seconds_tens, seconds_ones} !== 12'h001) begin
      bad++;
      $display("FAIL dec2: got %h want 001", {minutes, seconds_tens, seconds_ones});
    end
    cycles(3);
    total++;
    if (done !== 1'b0 || magnetron_on !== 1'b1) begin
      bad++;
      $display("FAIL pre_done: got done=%b mag=%b want done=0 mag=1", done, magnetron_on);
    end
    cycles(1);
    total++;
    if ({minutes, seconds_tens, seconds_ones} !== 12'h000 || done !== 1'b1 || magnetron_on !== 1'b0) begin
      bad++;
      $display("FAIL dec3_done: got %h done=%b mag=%b want 000 done=1 mag=0", {minutes, seconds_tens, seconds_ones}, done, magnetron_on);
    end
    pulse_start();
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL done_start_ignored: got done=%b want 1", done);
    end
    press_key(4'd8);
    total++;
    if (done !== 1'b0 || dut.r_state !== IDLE || {minutes, seconds_tens, seconds_ones} !== 12'h000) begin
      bad++;
      $display("FAIL done_key_exit: got done=%b state=%0d %h want done=0 state=%0d 000", done, dut.r_state, {minutes, seconds_tens, seconds_ones}, IDLE);
    end
  endtask

  task automatic test_borrow();
    press_key(4'd1);
    press_key(4'd0);
    press_key(4'd0);
    pulse_start();
    cycles(4);
    total++;
    if ({minutes, seconds_tens, seconds_ones} !== 12'h059) begin
      bad++;
      $display("FAIL borrow_min: got %h want 059", {minutes, seconds_tens, seconds_ones});
    end
    pulse_stop();
    pulse_stop();
    press_key(4'd1);
    press_key(4'd0);
    pulse_start();
    cycles(4);
    total++;
    if ({minutes, seconds_tens, seconds_ones} !== 12'h009) begin
      bad++;
      $display("FAIL borrow_tens: got %h want 009", {minutes, seconds_tens, seconds_ones});
    end
    pulse_stop();
    pulse_stop();
  endtask

  task automatic test_pause();
    press_key(4'd5);
    pulse_start();
    cycles(2);
    door_closed = 1'b0;
    cycles(1);
    total++;
    if (dut.r_state !== PAUSE || magnetron_on !== 1'b0) begin
      bad++;
      $display("FAIL door_pause: got state=%0d mag=%b want state=%0d mag=0", dut.r_state, magnetron_on, PAUSE);
    end
    pulse_start();
    cycles(5);
    total++;
    if ({minutes, seconds_tens, seconds_ones} !== 12'h005 || dut.r_state !== PAUSE) begin
      bad++;
      $display("FAIL pause_hold: got %h state=%0d want 005 state=%0d", {minutes, seconds_tens, seconds_ones}, dut.r_state, PAUSE);
    end
    door_closed = 1'b1;
    cycles(1);
    pulse_start();
    total++;
    if (magnetron_on !== 1'b1) begin
      bad++;
      $display("FAIL resume: got mag=%b want 1", magnetron_on);
    end
    cycles(3);
    total++;
    if ({minutes, seconds_tens, seconds_ones} !== 12'h005) begin
      bad++;
      $display("FAIL resume_early: got %h want 005", {minutes, seconds_tens, seconds_ones});
    end
    cycles(1);
    total++;
    if ({minutes, seconds_tens, seconds_ones} !== 12'h004) begin
      bad++;
      $display("FAIL resume_dec: got %h want 004", {minutes, seconds_tens, seconds_ones});
    end
    pulse_stop();
    total++;
    if (dut.r_state !== PAUSE || {minutes, seconds_tens, seconds_ones} !== 12'h004) begin
      bad++;
      $display("FAIL run_stop: got state=%0d %h want state=%0d 004", dut.r_state, {minutes, seconds_tens, seconds_ones}, PAUSE);
    end
    pulse_stop();
    total++;
    if (dut.r_state !== IDLE || {minutes, seconds_tens, seconds_ones} !== 12'h000) begin
      bad++;
      $display("FAIL pause_stop: got state=%0d %h want state=%0d 000", dut.r_state, {minutes, seconds_tens, seconds_ones}, IDLE);
    end
  endtask

  task automatic test_key_reject();
    press_key(4'd7);
    press_key(4'd4);
    total++;
    if ({minutes, seconds_tens, seconds_ones} !== 12'h007) begin
      bad++;
      $display("FAIL key_gt5_ignored: got %h want 007", {minutes, seconds_tens, seconds_ones});
    end
    pulse_stop();
    press_key(4'd2);
    press_key(4'd12);
    total++;
    if ({minutes, seconds_tens, seconds_ones} !== 12'h002) begin
      bad++;
      $display("FAIL key_non_bcd: got %h want 002", {minutes, seconds_tens, seconds_ones});
    end
    pulse_stop();
    pulse_start();
`ifdef MICROWAVE_QUICK_START_EN
    total++;
    if ({minutes, seconds_tens, seconds_ones} !== 12'h030 || magnetron_on !== 1'b1) begin
      bad++;
      $display("FAIL idle_start: got %h mag=%b want 030 mag=1", {minutes, seconds_tens, seconds_ones}, magnetron_on);
    end
    pulse_stop();
    pulse_stop();
`else
    total++;
    if ({minutes, seconds_tens, seconds_ones} !== 12'h000 || magnetron_on !== 1'b0 || dut.r_state !== IDLE) begin
      bad++;
      $display("FAIL idle_start: got %h mag=%b state=%0d want 000 mag=0 state=%0d", {minutes, seconds_tens, seconds_ones}, magnetron_on, dut.r_state, IDLE);
    end
`endif
  endtask

  task automatic test_stop_start_same();
    press_key(4'd2);
    @(negedge clk);
    stop  = 1'b1;
    start = 1'b1;
    @(negedge clk);
    stop  = 1'b0;
    start = 1'b0;
    total++;
    if (dut.r_state !== IDLE || magnetron_on !== 1'b0 || {minutes, seconds_tens, seconds_ones} !== 12'h000) begin
      bad++;
      $display("FAIL stop_over_start: got state=%0d mag=%b %h want state=%0d mag=0 000", dut.r_state, magnetron_on, {minutes, seconds_tens, seconds_ones}, IDLE);
    end
  endtask

  task automatic test_done_door();
    press_key(4'd1);
    pulse_start();
    cycles(4);
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL done_001: got done=%b want 1", done);
    end
    door_closed = 1'b0;
    cycles(1);
    total++;
    if (done !== 1'b0 || dut.r_state !== IDLE) begin
      bad++;
      $display("FAIL done_door_exit: got done=%b state=%0d want done=0 state=%0d", done, dut.r_state, IDLE);
    end
    door_closed = 1'b1;
    cycles(1);
  endtask

  task automatic test_reset_mid_run();
    press_key(4'd9);
    pulse_start();
    cycles(2);
    rst_n = 1'b0;
    cycles(1);
    total++;
    if ({minutes, seconds_tens, seconds_ones, magnetron_on, done} !== 14'h0 || dut.r_state !== IDLE) begin
      bad++;
      $display("FAIL reset_mid_run: got %h mag=%b done=%b state=%0d want 000 0 0 state=%0d", {minutes, seconds_tens, seconds_ones}, magnetron_on, done, dut.r_state, IDLE);
    end
    rst_n = 1'b1;
    cycles(1);
  endtask

  initial begin
    rst_n       = 1'b0;
    key_valid   = 1'b0;
    key_digit   = 4'd0;
    start       = 1'b0;
    stop        = 1'b0;
    door_closed = 1'b1;
    test_reset();
    test_key_entry();
    test_countdown();
    test_borrow();
    test_pause();
    test_key_reject();
    test_stop_start_same();
    test_done_door();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
